// File: rtl/regfile_dump_pkg.sv
// Shared processor definitions for the register-file dump engine.
// The header tag is also what the host-side decoder keys on.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [2:0] HDR_TAG   = 3'b000;
  localparam int         REC_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

  function automatic logic [7:0] makeHeader(input logic [REG_ADDR_W-1:0] addr);
    return {HDR_TAG, addr};
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Walks a wrap-around register range and streams each value as a
// 5-byte record (header + 4 data bytes, MSB first) over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_add_i,
  input  logic [ADDR_W-1:0] last_add_i,
  output logic [ADDR_W-1:0] rd_add_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] curAdd_q, curAdd_d;
  logic [ADDR_W-1:0] lastAdd_q, lastAdd_d;
  logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
  logic [2:0]        byteCnt_q, byteCnt_d;
  logic              busy_q, done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      curAdd_q   <= '0;
      lastAdd_q  <= '0;
      shiftReg_q <= '0;
      byteCnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      curAdd_q   <= curAdd_d;
      lastAdd_q  <= lastAdd_d;
      shiftReg_q <= shiftReg_d;
      byteCnt_q  <= byteCnt_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  // The register value is frozen in LOAD; later register-file writes only
  // show up in the next record that loads that address.
  always_comb begin
    state_d    = state_q;
    curAdd_d   = curAdd_q;
    lastAdd_d  = lastAdd_q;
    shiftReg_d = shiftReg_q;
    byteCnt_d  = byteCnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          curAdd_d  = first_add_i;
          lastAdd_d = last_add_i;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        shiftReg_d = rd_data_i;
        byteCnt_d  = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready_i) begin
          if (byteCnt_q != 3'd0) begin
            shiftReg_d = shiftReg_q << 8;
          end
          if (byteCnt_q == 3'(REC_BYTES - 1)) begin
            byteCnt_d = '0;
            if (curAdd_q == lastAdd_q) begin
              state_d = DONE;
            end else begin
              curAdd_d = curAdd_q + ADDR_W'(1);
              state_d  = LOAD;
            end
          end else begin
            byteCnt_d = byteCnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stream outputs decode only registered state, so they hold steady
  // through any number of stalled cycles and never see tx_ready_i.
  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == SEND) begin
      if (byteCnt_q == 3'd0) begin
        tx_data_o = makeHeader(curAdd_q);
      end else begin
        tx_data_o = shiftReg_q[DATA_W-1 -: 8];
      end
    end
  end

  assign tx_valid_o = (state_q == SEND);
  assign rd_add_o   = curAdd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: byte streams are compared against a
// record list built straight from the range rule and register contents.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  first_add;
  logic [4:0]  last_add;
  logic [4:0]  rd_add;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  logic [7:0]  got [$];
  bit          randReady;
  bit          prevStall;
  logic [7:0]  prevData;
  int          checks;
  int          fails;

  regfile_dump dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .first_add_i (first_add),
    .last_add_i  (last_add),
    .rd_add_o    (rd_add),
    .rd_data_i   (rd_data),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign rd_data = rf[rd_add];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink readiness changes just after each rising edge
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Byte capture and stall-stability checks, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall valid held", 32'(tx_valid), 32'd1);
        checkOutput("stall data held", 32'(tx_data), 32'(prevData));
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
    end
  end

  task automatic applyStimulus(input string tag, input logic [4:0] f, input logic [4:0] l,
                               input bit rr, input int doneAt, input bit noisy,
                               input int pokeAt, input logic [4:0] pokeAdd,
                               input logic [31:0] pokeVal);
    logic [7:0] exp [$];
    logic [4:0] a;
    int n;
    int k;
    bit seen;
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    for (int i = 0; i < n; i++) begin
      a = f + 5'(i);
      exp.push_back({3'b000, a});
      for (int b = 3; b >= 0; b--) exp.push_back(rf[a][8*b +: 8]);
    end
    got.delete();
    randReady = rr;
    @(negedge clk);
    first_add = f;
    last_add  = l;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy in load"}, 32'(busy), 32'd1);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 6000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (k == pokeAt) rf[pokeAdd] = pokeVal;
        if (noisy) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
    if (doneAt != 0) checkOutput({tag, " done cycle"}, 32'(k), 32'(doneAt));
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, " no queued start"}, 32'(busy), 32'd0);
    randReady = 1'b0;
    checkOutput({tag, " byte count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checkOutput($sformatf("%s byte %0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int k;
    checks    = 0;
    fails     = 0;
    randReady = 1'b0;
    prevStall = 1'b0;
    prevData  = 8'h00;
    rst       = 1'b1;
    start     = 1'b0;
    first_add = 5'd0;
    last_add  = 5'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset rd_add", 32'(rd_add), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    rf[5] = 32'hDEADBEEF;
    applyStimulus("single", 5'd5, 5'd5, 1'b0, 7, 1'b0, 0, 5'd0, 32'h0);

    for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
    applyStimulus("full", 5'd0, 5'd31, 1'b0, 193, 1'b0, 0, 5'd0, 32'h0);
    applyStimulus("wrap", 5'd30, 5'd1, 1'b0, 25, 1'b0, 0, 5'd0, 32'h0);
    applyStimulus("backpressure", 5'd3, 5'd12, 1'b1, 0, 1'b1, 0, 5'd0, 32'h0);

    rf[7] = 32'h0;
    applyStimulus("snapshot", 5'd7, 5'd7, 1'b0, 7, 1'b0, 3, 5'd7, 32'h12345678);
    applyStimulus("snapshot next", 5'd7, 5'd7, 1'b0, 7, 1'b0, 0, 5'd0, 32'h0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      applyStimulus($sformatf("random%0d", r), 5'($urandom), 5'($urandom), 1'b1, 0, 1'b1,
                    0, 5'd0, 32'h0);
    end

    // Abort during the third byte of the second record
    @(negedge clk);
    first_add = 5'd0;
    last_add  = 5'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("pre-abort tx_valid", 32'(tx_valid), 32'd1);
    checkOutput("pre-abort rd_add", 32'(rd_add), 32'd1);
    checkOutput("pre-abort tx_data", 32'(tx_data), 32'(rf[1][23:16]));
    rst = 1'b1;
    #1;
    checkOutput("abort tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rd_add", 32'(rd_add), 32'd0);
    checkOutput("abort tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rf[2] = 32'hA5C30F12;
    applyStimulus("after abort", 5'd2, 5'd2, 1'b0, 7, 1'b0, 0, 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
